// File: rtl/interface_hcsr04.sv
// HC-SR04 ultrasonic ranger controller: fires a trigger pulse, times the echo and reports cm in 3 BCD digits.
// Latency: trigger rises 2 cycles after medir is sampled; pronto rises 4 cycles after the synchroniser samples echo low.
// Backpressure: none; medir is a level request honoured only in inicial/erro, echo is sampled unconditionally.
module interface_hcsr04 #(
    parameter int CLK_PER_CM     = 2941,
    parameter int TRIGGER_CYCLES = 500,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam logic [3:0] S_INICIAL       = 4'h0;
    localparam logic [3:0] S_PREPARACAO    = 4'h1;
    localparam logic [3:0] S_ENVIA_TRIGGER = 4'h2;
    localparam logic [3:0] S_ESPERA_ECHO   = 4'h3;
    localparam logic [3:0] S_MEDIDA        = 4'h4;
    localparam logic [3:0] S_ARMAZENAMENTO = 4'h5;
    localparam logic [3:0] S_FINAL_MEDIDA  = 4'h6;
    localparam logic [3:0] S_ERRO          = 4'hF;

    // One counter times both the trigger pulse and the echo timeouts.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIGGER_CYCLES) ? TIMEOUT_CYCLES : TRIGGER_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int YW      = $clog2(CLK_PER_CM + 1);

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIGGER_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [YW-1:0] CYC_LAST  = YW'(CLK_PER_CM - 1);

    logic           echo_meta_q, echo_sync_q;
    logic [3:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [YW-1:0]  cyc_q, cyc_d;
    logic [11:0]    bcd_q, bcd_d;
    logic [11:0]    medida_q, medida_d;
    logic           erro_q, erro_d;
    logic           trigger_q, pronto_q;
    logic           count_en;

    // Decimal increment of a 3-digit BCD value, sticking at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchroniser for the asynchronous echo line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
        end
    end

    // Next-state, counter and result logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        cyc_d    = cyc_q;
        bcd_d    = bcd_q;
        medida_d = medida_q;
        erro_d   = erro_q;
        count_en = 1'b0;
        case (state_q)
            S_INICIAL: begin
                cnt_d = '0;
                if (medir) state_d = S_PREPARACAO;
            end
            S_PREPARACAO: begin
                cnt_d   = '0;
                cyc_d   = '0;
                bcd_d   = '0;
                state_d = S_ENVIA_TRIGGER;
            end
            S_ENVIA_TRIGGER: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ESPERA_ECHO;
                end
            end
            S_ESPERA_ECHO: begin
                if (echo_sync_q) begin
                    // The first high cycle is counted here, so cnt tracks echo-high cycles from 1.
                    count_en = 1'b1;
                    cnt_d    = CW'(1);
                    state_d  = S_MEDIDA;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    erro_d  = 1'b1;
                    state_d = S_ERRO;
                end
            end
            S_MEDIDA: begin
                if (!echo_sync_q) begin
                    cnt_d   = '0;
                    state_d = S_ARMAZENAMENTO;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    erro_d  = 1'b1;
                    state_d = S_ERRO;
                end else begin
                    count_en = 1'b1;
                end
            end
            S_ARMAZENAMENTO: begin
                cnt_d    = '0;
                medida_d = bcd_q;
                erro_d   = 1'b0;
                state_d  = S_FINAL_MEDIDA;
            end
            S_FINAL_MEDIDA: begin
                cnt_d   = '0;
                state_d = S_INICIAL;
            end
            S_ERRO: begin
                cnt_d = '0;
                if (medir) state_d = S_PREPARACAO;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_INICIAL;
            end
        endcase
        // Whole centimetres only: a partial count left in cyc is discarded.
        if (count_en) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                bcd_d = bcd_inc(bcd_q);
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    // State registers; trigger and pronto are registered decodes so they cannot glitch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_INICIAL;
            cnt_q     <= '0;
            cyc_q     <= '0;
            bcd_q     <= '0;
            medida_q  <= '0;
            erro_q    <= 1'b0;
            trigger_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            bcd_q     <= bcd_d;
            medida_q  <= medida_d;
            erro_q    <= erro_d;
            trigger_q <= (state_q == S_ENVIA_TRIGGER);
            pronto_q  <= (state_q == S_FINAL_MEDIDA);
        end
    end

    assign trigger   = trigger_q;
    assign medida    = medida_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04.sv
// Directed bench for interface_hcsr04 with a short centimetre and timeout so every case fits a short run.
// Latency: checks trigger and pronto timing cycle-exactly against hand-derived values.
// Backpressure: not applicable; the bench drives medir/echo directly.
module tb_interface_hcsr04;

    localparam int CPC  = 4;
    localparam int TRIG = 500;
    localparam int TO   = 6000;

    logic        clock = 1'b0;
    logic        reset;
    logic        medir;
    logic        echo;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    int tests = 0;
    int fails = 0;
    int pronto_cnt = 0;
    int trig_rise = 0;
    logic trig_d = 1'b0;

    interface_hcsr04 #(
        .CLK_PER_CM    (CPC),
        .TRIGGER_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .medir    (medir),
        .echo     (echo),
        .trigger  (trigger),
        .medida   (medida),
        .pronto   (pronto),
        .erro     (erro),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle.
    always @(negedge clock) begin
        if (pronto === 1'b1) pronto_cnt <= pronto_cnt + 1;
        if (trigger === 1'b1 && trig_d === 1'b0) trig_rise <= trig_rise + 1;
        trig_d <= trigger;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int k = 0;
        while (db_estado !== s && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, {28'd0, db_estado}, {28'd0, s});
    endtask

    // Pulse medir for one cycle and check the trigger start latency.
    task automatic start_meas(input string tag);
        medir = 1'b1;
        tick();
        medir = 1'b0;
        tick();
        check_eq({tag, " trig early"}, {31'd0, trigger}, 32'd0);
        tick();
        check_eq({tag, " trig lat"}, {31'd0, trigger}, 32'd1);
    endtask

    task automatic trig_width(input string tag);
        int w = 0;
        while (trigger === 1'b1 && w < TRIG + 10) begin
            w++;
            tick();
        end
        check_eq({tag, " trig width"}, w, TRIG);
    endtask

    // Drive echo for n cycles once espera_echo is reached, then check pronto timing and result.
    task automatic finish_echo(input int n, input logic [11:0] exp, input string tag);
        int k = 0;
        wait_state(4'h3, 50, {tag, " espera"});
        echo = 1'b1;
        repeat (n) tick();
        echo = 1'b0;
        while (pronto !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check_eq({tag, " pronto lat"}, k, 5);
        check_eq({tag, " medida"}, {20'd0, medida}, {20'd0, exp});
        check_eq({tag, " erro"}, {31'd0, erro}, 32'd0);
        tick();
        check_eq({tag, " pronto 1cyc"}, {31'd0, pronto}, 32'd0);
    endtask

    initial begin
        int pc0;
        int tr0;
        reset = 1'b1;
        medir = 1'b0;
        echo  = 1'b0;
        tick();
        tick();
        check_eq("rst trigger", {31'd0, trigger}, 32'd0);
        check_eq("rst medida", {20'd0, medida}, 32'd0);
        check_eq("rst pronto", {31'd0, pronto}, 32'd0);
        check_eq("rst erro", {31'd0, erro}, 32'd0);
        check_eq("rst estado", {28'd0, db_estado}, 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        check_eq("idle estado", {28'd0, db_estado}, 32'd0);

        // 25 cm with one pronto and one trigger pulse.
        pc0 = pronto_cnt;
        tr0 = trig_rise;
        start_meas("m25");
        trig_width("m25");
        finish_echo(25 * CPC, 12'h025, "m25");
        check_eq("m25 pronto count", pronto_cnt - pc0, 1);
        check_eq("m25 trig count", trig_rise - tr0, 1);

        // Truncation boundary.
        start_meas("m0");
        trig_width("m0");
        finish_echo(CPC - 1, 12'h000, "m0");
        start_meas("m1");
        trig_width("m1");
        finish_echo(CPC, 12'h001, "m1");

        // Decimal carries and saturation.
        start_meas("m400");
        trig_width("m400");
        finish_echo(400 * CPC, 12'h400, "m400");
        start_meas("m999");
        trig_width("m999");
        finish_echo(1000 * CPC, 12'h999, "m999");

        // Echo never rises: timeout into erro, medida retained.
        pc0 = pronto_cnt;
        start_meas("to");
        trig_width("to");
        repeat (TO - 2) tick();
        check_eq("to still waiting", {28'd0, db_estado}, 32'h3);
        tick();
        check_eq("to estado", {28'd0, db_estado}, 32'hF);
        check_eq("to erro", {31'd0, erro}, 32'd1);
        check_eq("to medida kept", {20'd0, medida}, 32'h999);
        repeat (10) tick();
        check_eq("to hold estado", {28'd0, db_estado}, 32'hF);
        check_eq("to no pronto", pronto_cnt - pc0, 0);
        start_meas("rec");
        trig_width("rec");
        finish_echo(10 * CPC, 12'h010, "rec");

        // Reset mid-trigger.
        start_meas("rtrg");
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check_eq("rtrg trigger", {31'd0, trigger}, 32'd0);
        check_eq("rtrg estado", {28'd0, db_estado}, 32'd0);
        check_eq("rtrg medida", {20'd0, medida}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        start_meas("m5");
        trig_width("m5");
        finish_echo(5 * CPC, 12'h005, "m5");

        // Reset mid-echo.
        start_meas("recho");
        trig_width("recho");
        wait_state(4'h3, 50, "recho espera");
        echo = 1'b1;
        repeat (20) tick();
        check_eq("recho in medida", {28'd0, db_estado}, 32'h4);
        pc0 = pronto_cnt;
        reset = 1'b1;
        #1;
        check_eq("recho trigger", {31'd0, trigger}, 32'd0);
        check_eq("recho estado", {28'd0, db_estado}, 32'd0);
        check_eq("recho medida", {20'd0, medida}, 32'd0);
        echo = 1'b0;
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check_eq("recho no pronto", pronto_cnt - pc0, 0);
        check_eq("recho idle", {28'd0, db_estado}, 32'd0);

        // medir held: back-to-back measurements, one pronto and one trigger each.
        pc0 = pronto_cnt;
        tr0 = trig_rise;
        medir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int k = 0;
            while (trigger !== 1'b1 && k < 20) begin
                tick();
                k++;
            end
            trig_width("hold");
            if (i == 0) finish_echo(3 * CPC, 12'h003, "hold3");
            else if (i == 1) finish_echo(7 * CPC, 12'h007, "hold7");
            else finish_echo(12 * CPC, 12'h012, "hold12");
        end
        medir = 1'b0;
        begin
            int k = 0;
            while (trigger !== 1'b1 && k < 20) begin
                tick();
                k++;
            end
        end
        trig_width("hold last");
        finish_echo(1 * CPC, 12'h001, "hold1");
        repeat (5) tick();
        check_eq("hold pronto count", pronto_cnt - pc0, 4);
        check_eq("hold trig count", trig_rise - tr0, 4);
        check_eq("hold idle", {28'd0, db_estado}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
